// File: rtl/mem_responder.sv
// Purpose  : memory-side responder for the multicycle core's unified instruction/data port.
// Latency  : fixed LATENCY cycles from request acceptance to the one-cycle mem_ready pulse.
// Backpress: one request at a time; busy is high while waiting, and requests are only accepted in IDLE.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   mem_read   read request (level, held until mem_ready)
//   mem_write  write request (level, held until mem_ready)
//   addr       byte address; bits above ADDR_WIDTH+1 are ignored (addresses wrap)
//   wdata      write data
//   rdata      read data, updated only when a legal read completes
//   mem_ready  one-cycle completion pulse
//   mem_err    error flag (misaligned or read+write together), coincident with mem_ready
//   busy       high while a request is outstanding
module mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int AW2   = ADDR_WIDTH + 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [3:0]      cnt;

  // Holding registers for the accepted request.
  logic [AW2-1:0]  addr_cap;
  logic [31:0]     wdata_cap;
  logic            rd_cap;
  logic            wr_cap;
  logic            err_q;

  logic [31:0]     mem [DEPTH];

  // Upper address bits alias away; they are intentionally not used.
  logic [31-AW2:0] addr_unused;
  assign addr_unused = addr[31:AW2];

  logic                  in_idle;
  logic                  accept;
  logic                  enter_resp;
  logic [AW2-1:0]        cur_addr;
  logic [31:0]           cur_wdata;
  logic                  cur_rd;
  logic                  cur_wr;
  logic                  cur_err;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  mem_we;
  logic                  rd_upd;

  assign in_idle = (state == IDLE);
  assign accept  = in_idle && (mem_read || mem_write);

  // With LATENCY=1 the request is accepted on the same edge that enters RESP,
  // so the live inputs must be used instead of the (not yet loaded) captures.
  assign cur_addr  = in_idle ? addr[AW2-1:0] : addr_cap;
  assign cur_wdata = in_idle ? wdata         : wdata_cap;
  assign cur_rd    = in_idle ? mem_read      : rd_cap;
  assign cur_wr    = in_idle ? mem_write     : wr_cap;

  assign cur_err = (cur_addr[1:0] != 2'b00) || (cur_rd && cur_wr);
  assign idx     = cur_addr[AW2-1:2];

  assign enter_resp = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == 4'd1));

  // Gated by reset so an access cannot commit while reset is held.
  assign mem_we = reset && enter_resp && cur_wr && !cur_err;
  assign rd_upd = enter_resp && cur_rd && !cur_err;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt == 4'd1) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      addr_cap  <= '0;
      wdata_cap <= 32'd0;
      rd_cap    <= 1'b0;
      wr_cap    <= 1'b0;
      err_q     <= 1'b0;
      rdata     <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_cap  <= addr[AW2-1:0];
        wdata_cap <= wdata;
        rd_cap    <= mem_read;
        wr_cap    <= mem_write;
        cnt       <= 4'(LATENCY - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        err_q <= cur_err;
      end
      if (rd_upd) begin
        rdata <= mem[idx];
      end
    end
  end

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= cur_wdata;
    end
  end

  assign busy      = (state == WAIT);
  assign mem_ready = (state == RESP);
  assign mem_err   = (state == RESP) && err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int AW = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd   [3];
  logic        wr   [3];
  logic [31:0] ad   [3];
  logic [31:0] wd   [3];
  logic [31:0] rdat [3];
  logic        rdy  [3];
  logic        err  [3];
  logic        bsy  [3];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(AW), .LATENCY(2)) u0 (
    .clk(clk), .reset(reset), .mem_read(rd[0]), .mem_write(wr[0]), .addr(ad[0]), .wdata(wd[0]),
    .rdata(rdat[0]), .mem_ready(rdy[0]), .mem_err(err[0]), .busy(bsy[0]));
  mem_responder #(.ADDR_WIDTH(AW), .LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .mem_read(rd[1]), .mem_write(wr[1]), .addr(ad[1]), .wdata(wd[1]),
    .rdata(rdat[1]), .mem_ready(rdy[1]), .mem_err(err[1]), .busy(bsy[1]));
  mem_responder #(.ADDR_WIDTH(AW), .LATENCY(3)) u2 (
    .clk(clk), .reset(reset), .mem_read(rd[2]), .mem_write(wr[2]), .addr(ad[2]), .wdata(wd[2]),
    .rdata(rdat[2]), .mem_ready(rdy[2]), .mem_err(err[2]), .busy(bsy[2]));

  int tests = 0;
  int fails = 0;

  function automatic int lat_of(input int d);
    case (d)
      0: return 2;
      1: return 1;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: each request completes LATENCY edges after acceptance,
  // followed by a single response cycle in which no new request is taken.
  int          left   [3] = '{0, 0, 0};
  bit          resp   [3] = '{0, 0, 0};
  bit          c_rd   [3];
  bit          c_wr   [3];
  logic [31:0] c_ad   [3];
  logic [31:0] c_wd   [3];
  logic [31:0] m_rdat [3] = '{32'd0, 32'd0, 32'd0};
  bit          m_err  [3] = '{0, 0, 0};
  logic [31:0] mmem   [int];

  task automatic model_complete(input int d);
    int key;
    key = d * 1024 + int'((c_ad[d] >> 2) % (1 << AW));
    m_err[d] = (c_ad[d] % 4 != 0) || (c_rd[d] && c_wr[d]);
    if (!m_err[d]) begin
      if (c_wr[d]) mmem[key] = c_wd[d];
      if (c_rd[d]) m_rdat[d] = mmem.exists(key) ? mmem[key] : 32'hxxxxxxxx;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    for (int d = 0; d < 3; d++) begin
      if (!reset) begin
        left[d] = 0; resp[d] = 0; m_rdat[d] = 32'd0; m_err[d] = 0;
      end else begin
        if (resp[d]) begin
          resp[d] = 0;
        end else if (left[d] == 0 && (rd[d] || wr[d])) begin
          c_rd[d] = rd[d]; c_wr[d] = wr[d]; c_ad[d] = ad[d]; c_wd[d] = wd[d];
          left[d] = lat_of(d);
        end
        if (left[d] > 0) begin
          left[d]--;
          if (left[d] == 0) begin
            resp[d] = 1;
            model_complete(d);
          end
        end
      end
    end
  end

  // Per-cycle comparison of every DUT against the model.
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("u%0d busy", d),      32'(bsy[d]), 32'(left[d] > 0));
      chk($sformatf("u%0d mem_ready", d), 32'(rdy[d]), 32'(resp[d]));
      chk($sformatf("u%0d mem_err", d),   32'(err[d]), 32'(resp[d] && m_err[d]));
      chk($sformatf("u%0d rdata", d),     rdat[d],     m_rdat[d]);
    end
  end

  // Called at negedge+1 in an idle cycle; returns at negedge+1 in the next idle cycle.
  task automatic do_req(input int d, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] wv, input bit chg, input logic [31:0] a2,
                        output logic [31:0] rv, output bit ev, output int lat);
    rd[d] = r; wr[d] = w; ad[d] = a; wd[d] = wv;
    lat = 0; ev = 0; rv = 32'd0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rdy[d]) begin
        lat = i; rv = rdat[d]; ev = err[d];
        break;
      end
      if (chg && i == 1) ad[d] = a2;
    end
    tests++;
    if (lat == 0) begin
      fails++;
      $display("FAIL u%0d timeout: mem_ready seen 0, required 1 within 40 cycles", d);
    end
    #1 rd[d] = 0; wr[d] = 0;
    @(negedge clk);
    #1;
  endtask

  logic [31:0] rv;
  bit          ev;
  int          lat;
  logic [7:0]  pat;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rd[d] = 0; wr[d] = 0; ad[d] = 32'd0; wd[d] = 32'd0;
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy",  32'(bsy[0]), 32'd0);
    chk("reset ready", 32'(rdy[0]), 32'd0);
    chk("reset err",   32'(err[0]), 32'd0);
    chk("reset rdata", rdat[0],     32'd0);
    #1 reset = 1'b1;
    @(negedge clk);
    #1;

    // Write then read, LATENCY=2.
    do_req(0, 0, 1, 32'h04, 32'h12345678, 0, 0, rv, ev, lat);
    chk("wr lat", 32'(lat), 32'd2);
    chk("wr err", 32'(ev), 32'd0);
    do_req(0, 1, 0, 32'h04, 32'h0, 0, 0, rv, ev, lat);
    chk("rd lat", 32'(lat), 32'd2);
    chk("rd data", rv, 32'h12345678);
    chk("rd err", 32'(ev), 32'd0);

    // Misaligned write.
    do_req(0, 0, 1, 32'h06, 32'h77777777, 0, 0, rv, ev, lat);
    chk("misal err", 32'(ev), 32'd1);
    chk("misal lat", 32'(lat), 32'd2);
    chk("misal rdata kept", rv, 32'h12345678);
    do_req(0, 1, 0, 32'h04, 32'h0, 0, 0, rv, ev, lat);
    chk("misal mem kept", rv, 32'h12345678);

    // Read and write together.
    do_req(0, 1, 1, 32'h04, 32'h0, 0, 0, rv, ev, lat);
    chk("both err", 32'(ev), 32'd1);
    chk("both rdata kept", rv, 32'h12345678);
    do_req(0, 1, 0, 32'h04, 32'h0, 0, 0, rv, ev, lat);
    chk("both mem kept", rv, 32'h12345678);

    // Aliasing: 0x400 wraps to word 0.
    do_req(0, 0, 1, 32'h400, 32'hA5A5A5A5, 0, 0, rv, ev, lat);
    do_req(0, 1, 0, 32'h000, 32'h0, 0, 0, rv, ev, lat);
    chk("alias data", rv, 32'hA5A5A5A5);

    // Reset during WAIT aborts the write.
    do_req(0, 0, 1, 32'h10, 32'h11111111, 0, 0, rv, ev, lat);
    wr[0] = 1; ad[0] = 32'h10; wd[0] = 32'hDEADBEEF;
    @(negedge clk);
    chk("abort busy before", 32'(bsy[0]), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("abort busy",  32'(bsy[0]), 32'd0);
    chk("abort ready", 32'(rdy[0]), 32'd0);
    chk("abort err",   32'(err[0]), 32'd0);
    chk("abort rdata", rdat[0],     32'd0);
    wr[0] = 0;
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    #1;
    do_req(0, 1, 0, 32'h10, 32'h0, 0, 0, rv, ev, lat);
    chk("abort old data", rv, 32'h11111111);

    // LATENCY=1 back-to-back with read held high.
    do_req(1, 0, 1, 32'h20, 32'h5A5A0001, 0, 0, rv, ev, lat);
    chk("l1 wr lat", 32'(lat), 32'd1);
    rd[1] = 1; ad[1] = 32'h20;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pat[i] = rdy[1];
    end
    #1 rd[1] = 0;
    chk("l1 ready pattern", 32'(pat), 32'h55);
    chk("l1 rdata", rdat[1], 32'h5A5A0001);
    @(negedge clk);
    #1;

    // LATENCY=3: address change during WAIT is ignored.
    do_req(2, 0, 1, 32'h08, 32'hCAFEF00D, 0, 0, rv, ev, lat);
    chk("l3 wr lat", 32'(lat), 32'd3);
    do_req(2, 0, 1, 32'h0C, 32'h0BADF00D, 0, 0, rv, ev, lat);
    do_req(2, 1, 0, 32'h08, 32'h0, 1, 32'h0C, rv, ev, lat);
    chk("l3 rd lat", 32'(lat), 32'd3);
    chk("l3 captured addr", rv, 32'hCAFEF00D);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
